// File: rtl/aska_spi_regfile.sv
// ---------------------------------------------------------------------------
// aska_spi_regfile
//
// SPI mode-0 slave register file for the ASKA analog front-end configuration.
// The SPI pins are oversampled in the clk domain, so all logic runs on clk.
// A frame is {rw, idx[AW-2:0], data[DW-1:0]}, MSB first. Writes commit when
// chip select rises after exactly AW+DW bits. Reads return the addressed
// register on SPI_MISO during the data phase.
//
// Ports
//   clk        system clock (>= 8x SPI_Clk)
//   resetn     asynchronous reset, active low
//   SPI_CS     chip select, active low, asynchronous
//   SPI_Clk    SPI clock, MOSI sampled on rise, MISO driven on fall
//   SPI_MOSI   serial data in, MSB first
//   SPI_MISO   serial data out, MSB first, 0 when not reading
//   regs       register bank, reg k = regs[k*DW +: DW]
//   wr_strobe  one-clk pulse on bit k when reg k is updated
//   frame_err  one-clk pulse when a frame is rejected
// ---------------------------------------------------------------------------
module aska_spi_regfile #(
    parameter int AW   = 8,
    parameter int DW   = 32,
    parameter int NREG = 4,
    parameter int SYNC = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               SPI_CS,
    input  logic               SPI_Clk,
    input  logic               SPI_MOSI,
    output logic               SPI_MISO,
    output logic [NREG*DW-1:0] regs,
    output logic [NREG-1:0]    wr_strobe,
    output logic               frame_err
);

    localparam int IW = AW - 1;
    localparam int CW = $clog2(AW + DW + 2);
    localparam logic [CW-1:0] CNT_FULL  = CW'(AW + DW);
    localparam logic [CW-1:0] CNT_SAT   = CW'(AW + DW + 1);
    localparam logic [CW-1:0] CNT_ALAST = CW'(AW - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WDATA,
        RDATA
    } state_t;

    state_t state_q, state_d;

    logic [SYNC-1:0]    csSync_q, sckSync_q, mosiSync_q;
    logic               csPrev_q, sckPrev_q;
    logic [CW-1:0]      count_q, count_d;
    logic [DW-1:0]      shift_q, shift_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [DW-1:0]      shadow_q, shadow_d;
    logic               miso_q, miso_d;
    logic [NREG*DW-1:0] regs_q, regs_d;
    logic [NREG-1:0]    strobe_q, strobe_d;
    logic               ferr_q, ferr_d;

    logic          csCur, sckCur, mosiCur;
    logic          csFall, csRise, sckRise, sckFall;
    logic [IW-1:0] addrIdx;
    logic          addrRw;
    logic          idxOk;

    // Synchroniser chains; CS idles high so its chain resets to 1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            csSync_q   <= '1;
            sckSync_q  <= '0;
            mosiSync_q <= '0;
            csPrev_q   <= 1'b1;
            sckPrev_q  <= 1'b0;
        end else begin
            csSync_q   <= {csSync_q[SYNC-2:0], SPI_CS};
            sckSync_q  <= {sckSync_q[SYNC-2:0], SPI_Clk};
            mosiSync_q <= {mosiSync_q[SYNC-2:0], SPI_MOSI};
            csPrev_q   <= csSync_q[SYNC-1];
            sckPrev_q  <= sckSync_q[SYNC-1];
        end
    end

    assign csCur   = csSync_q[SYNC-1];
    assign sckCur  = sckSync_q[SYNC-1];
    assign mosiCur = mosiSync_q[SYNC-1];
    assign csFall  = !csCur && csPrev_q;
    assign csRise  = csCur && !csPrev_q;
    assign sckRise = sckCur && !sckPrev_q;
    assign sckFall = !sckCur && sckPrev_q;

    // After AW-1 captured bits the shift register holds rw and the upper
    // index bits; the live MOSI bit completes the index.
    assign addrRw  = shift_q[IW-1];
    assign addrIdx = {shift_q[IW-2:0], mosiCur};
    assign idxOk   = ({1'b0, idx_q} < AW'(NREG));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            count_q  <= '0;
            shift_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            miso_q   <= 1'b0;
            regs_q   <= '0;
            strobe_q <= '0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            miso_q   <= miso_d;
            regs_q   <= regs_d;
            strobe_q <= strobe_d;
            ferr_q   <= ferr_d;
        end
    end

    // Frame sequencing, bit capture, commit/reject and MISO shifting.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        miso_d   = miso_q;
        regs_d   = regs_q;
        strobe_d = '0;
        ferr_d   = 1'b0;

        if (csFall) begin
            count_d = '0;
            state_d = ADDR;
        end else if (csRise) begin
            state_d = IDLE;
            miso_d  = 1'b0;
            if (state_q != IDLE) begin
                if (count_q == CNT_FULL && idxOk) begin
                    if (state_q == WDATA) begin
                        for (int k = 0; k < NREG; k++) begin
                            if (idx_q == IW'(k)) begin
                                regs_d[k*DW +: DW] = shift_q;
                                strobe_d[k]        = 1'b1;
                            end
                        end
                    end
                end else begin
                    ferr_d = 1'b1;
                end
            end
        end else if (!csCur && state_q != IDLE) begin
            if (sckRise && count_q != CNT_SAT) begin
                count_d = count_q + CW'(1);
                if (count_q < CNT_FULL) begin
                    shift_d = {shift_q[DW-2:0], mosiCur};
                end
                if (state_q == ADDR && count_q == CNT_ALAST) begin
                    idx_d    = addrIdx;
                    state_d  = addrRw ? RDATA : WDATA;
                    shadow_d = '0;
                    for (int k = 0; k < NREG; k++) begin
                        if (addrIdx == IW'(k)) begin
                            shadow_d = regs_q[k*DW +: DW];
                        end
                    end
                end
            end
            if (sckFall && state_q == RDATA) begin
                miso_d   = shadow_q[DW-1];
                shadow_d = {shadow_q[DW-2:0], 1'b0};
            end
        end

        if (state_q != RDATA) begin
            miso_d = 1'b0;
        end
    end

    assign SPI_MISO  = miso_q;
    assign regs      = regs_q;
    assign wr_strobe = strobe_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_aska_spi_regfile.sv
// ---------------------------------------------------------------------------
// tb_aska_spi_regfile
//
// Directed bench for aska_spi_regfile with default parameters. A table of
// SPI frames with hand-computed expected strobes, error pulses, register
// contents and readback words is applied in a loop, followed by hand-written
// sequences for reset mid-frame and back-to-back writes.
// ---------------------------------------------------------------------------
module tb_aska_spi_regfile;

    localparam int HALF = 6;

    logic         clk;
    logic         resetn;
    logic         SPI_CS;
    logic         SPI_Clk;
    logic         SPI_MOSI;
    logic         SPI_MISO;
    logic [127:0] regs;
    logic [3:0]   wr_strobe;
    logic         frame_err;

    int testsRun;
    int testsFailed;
    int errCount;
    logic [3:0] strobeLog[$];
    logic [127:0] expRegs;

    typedef struct {
        string       name;
        logic [39:0] frame;
        int          nbits;
        bit          checkMiso;
        logic [31:0] expMiso;
        logic [3:0]  expStrobe;
        int          expErr;
    } vec_t;

    vec_t vecs[11];

    aska_spi_regfile #(.AW(8), .DW(32), .NREG(4), .SYNC(2)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .SPI_CS    (SPI_CS),
        .SPI_Clk   (SPI_Clk),
        .SPI_MOSI  (SPI_MOSI),
        .SPI_MISO  (SPI_MISO),
        .regs      (regs),
        .wr_strobe (wr_strobe),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every strobe cycle and count error pulses, sampled on the falling edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (wr_strobe != 4'b0) strobeLog.push_back(wr_strobe);
            if (frame_err) errCount++;
        end
    end

    function automatic logic [39:0] mkFrame(input logic rw, input logic [6:0] idx,
                                            input logic [31:0] data);
        return {rw, idx, data};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift out the first nbits of a frame (zeros beyond bit 40), sampling
    // MISO just before each rising SCK edge as the master would.
    task automatic sendBits(input logic [39:0] frame, input int nbits,
                            output logic [63:0] misoBits);
        misoBits = '0;
        for (int i = 0; i < nbits; i++) begin
            SPI_MOSI = (i < 40) ? frame[39-i] : 1'b0;
            waitClk(HALF);
            misoBits = {misoBits[62:0], SPI_MISO};
            SPI_Clk = 1'b1;
            waitClk(HALF);
            SPI_Clk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [39:0] frame, input int nbits,
                                 input int gap, output logic [63:0] misoBits);
        SPI_CS = 1'b0;
        waitClk(HALF);
        sendBits(frame, nbits, misoBits);
        waitClk(HALF);
        SPI_CS   = 1'b1;
        SPI_MOSI = 1'b0;
        waitClk(gap);
    endtask

    function automatic logic [3:0] orLog();
        logic [3:0] m;
        m = 4'b0;
        foreach (strobeLog[i]) m |= strobeLog[i];
        return m;
    endfunction

    initial begin
        logic [63:0] misoBits;
        int idx;

        testsRun    = 0;
        testsFailed = 0;
        errCount    = 0;
        expRegs     = '0;
        SPI_CS      = 1'b1;
        SPI_Clk     = 1'b0;
        SPI_MOSI    = 1'b0;
        resetn      = 1'b0;

        vecs[0]  = '{"wr2",      mkFrame(1'b0, 7'd2, 32'hDEADBEEF), 40, 1'b0, 32'h0,        4'b0100, 0};
        vecs[1]  = '{"wr1_39b",  mkFrame(1'b0, 7'd1, 32'h12345678), 39, 1'b0, 32'h0,        4'b0000, 1};
        vecs[2]  = '{"rd2",      mkFrame(1'b1, 7'd2, 32'h0),        40, 1'b1, 32'hDEADBEEF, 4'b0000, 0};
        vecs[3]  = '{"wr5",      mkFrame(1'b0, 7'd5, 32'hCAFEF00D), 40, 1'b0, 32'h0,        4'b0000, 1};
        vecs[4]  = '{"rd5",      mkFrame(1'b1, 7'd5, 32'h0),        40, 1'b1, 32'h0,        4'b0000, 1};
        vecs[5]  = '{"wr1_41b",  mkFrame(1'b0, 7'd1, 32'h11112222), 41, 1'b0, 32'h0,        4'b0000, 1};
        vecs[6]  = '{"wr3",      mkFrame(1'b0, 7'd3, 32'h0F0F1234), 40, 1'b0, 32'h0,        4'b1000, 0};
        vecs[7]  = '{"rd3",      mkFrame(1'b1, 7'd3, 32'h0),        40, 1'b1, 32'h0F0F1234, 4'b0000, 0};
        vecs[8]  = '{"rd0",      mkFrame(1'b1, 7'd0, 32'h0),        40, 1'b1, 32'h0,        4'b0000, 0};
        vecs[9]  = '{"wr0",      mkFrame(1'b0, 7'd0, 32'h00000001), 40, 1'b0, 32'h0,        4'b0001, 0};
        vecs[10] = '{"rd1_addr", mkFrame(1'b1, 7'd1, 32'h0),        8,  1'b0, 32'h0,        4'b0000, 1};

        waitClk(4);
        checkOutput("reset_regs",   128'(regs),      128'h0);
        checkOutput("reset_strobe", 128'(wr_strobe), 128'h0);
        checkOutput("reset_ferr",   128'(frame_err), 128'h0);
        checkOutput("reset_miso",   128'(SPI_MISO),  128'h0);
        resetn = 1'b1;
        waitClk(6);

        for (int v = 0; v < 11; v++) begin
            strobeLog.delete();
            errCount = 0;
            applyStimulus(vecs[v].frame, vecs[v].nbits, 12, misoBits);
            if (vecs[v].expStrobe != 4'b0) begin
                idx = int'(vecs[v].frame[38:32]);
                expRegs[idx*32 +: 32] = vecs[v].frame[31:0];
            end
            checkOutput({vecs[v].name, "_strobe"}, 128'(orLog()), 128'(vecs[v].expStrobe));
            checkOutput({vecs[v].name, "_pulses"}, 128'(strobeLog.size()),
                        128'((vecs[v].expStrobe != 4'b0) ? 1 : 0));
            checkOutput({vecs[v].name, "_ferr"}, 128'(errCount), 128'(vecs[v].expErr));
            checkOutput({vecs[v].name, "_regs"}, regs, expRegs);
            if (vecs[v].checkMiso) begin
                checkOutput({vecs[v].name, "_miso"},  128'(misoBits[31:0]),  128'(vecs[v].expMiso));
                checkOutput({vecs[v].name, "_mhead"}, 128'(misoBits[39:32]), 128'h0);
            end
            checkOutput({vecs[v].name, "_idle_miso"}, 128'(SPI_MISO), 128'h0);
        end

        // Reset at bit 20 of a write to idx 0 aborts it and clears the bank.
        strobeLog.delete();
        errCount = 0;
        SPI_CS = 1'b0;
        waitClk(HALF);
        sendBits(mkFrame(1'b0, 7'd0, 32'h5A5A5A5A), 20, misoBits);
        resetn = 1'b0;
        waitClk(3);
        expRegs = '0;
        checkOutput("rst_mid_regs", regs, expRegs);
        checkOutput("rst_mid_strobe", 128'(wr_strobe), 128'h0);
        SPI_CS  = 1'b1;
        SPI_Clk = 1'b0;
        waitClk(3);
        resetn = 1'b1;
        waitClk(8);
        checkOutput("rst_mid_nolog", 128'(strobeLog.size()), 128'h0);
        checkOutput("rst_mid_noerr", 128'(errCount), 128'h0);
        applyStimulus(mkFrame(1'b0, 7'd0, 32'hA5A5A5A5), 40, 12, misoBits);
        expRegs[31:0] = 32'hA5A5A5A5;
        checkOutput("post_rst_strobe", 128'(orLog()), 128'h1);
        checkOutput("post_rst_regs", regs, expRegs);
        checkOutput("post_rst_ferr", 128'(errCount), 128'h0);

        // Back-to-back writes with minimum CS-high gap of SYNC+2 clocks.
        strobeLog.delete();
        errCount = 0;
        applyStimulus(mkFrame(1'b0, 7'd0, 32'h01234567), 40, 4, misoBits);
        applyStimulus(mkFrame(1'b0, 7'd3, 32'h89ABCDEF), 40, 12, misoBits);
        expRegs[31:0]   = 32'h01234567;
        expRegs[127:96] = 32'h89ABCDEF;
        checkOutput("b2b_count", 128'(strobeLog.size()), 128'h2);
        if (strobeLog.size() == 2) begin
            checkOutput("b2b_first",  128'(strobeLog[0]), 128'h1);
            checkOutput("b2b_second", 128'(strobeLog[1]), 128'h8);
        end
        checkOutput("b2b_regs", regs, expRegs);
        checkOutput("b2b_ferr", 128'(errCount), 128'h0);

        // A read in the frame right after a write returns the new value.
        errCount = 0;
        applyStimulus(mkFrame(1'b1, 7'd3, 32'h0), 40, 12, misoBits);
        checkOutput("rdnew_miso", 128'(misoBits[31:0]), 128'h89ABCDEF);
        checkOutput("rdnew_ferr", 128'(errCount), 128'h0);
        checkOutput("rdnew_regs", regs, expRegs);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
